// File: rtl/package_defs.sv
// Framing constants shared by the transmit framer and the receive/window path.
// Both ends must agree on package size, start byte, byte positions and function codes.
package package_defs;

  localparam int DATA_WIDTH       = 8;
  localparam int PACKAGE_SIZE     = 11;
  localparam int PAYLOAD_BYTES    = 8;
  localparam int PACKAGE_NO_INDEX = 6;

  // 1-indexed byte positions within a package
  localparam int PACKAGE_START = 1;
  localparam int PACKAGE_FUNC  = 2;
  localparam int PACKAGE_SUM   = 11;

  localparam logic [7:0] PACKAGE_START_BYTE = 8'h55;

  localparam logic [7:0] FUNC_ACCEL = 8'h51;
  localparam logic [7:0] FUNC_GYRO  = 8'h52;
  localparam logic [7:0] FUNC_ANGLE = 8'h53;

  // 0-based index of the checksum byte inside the framer
  localparam logic [3:0] LAST_IDX = 4'(PACKAGE_SUM - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } tx_state_e;

endpackage

// File: rtl/package_checksum.sv
// Package checksum: start byte + func + 8 payload bytes, summed mod 256.
// Ports: func_i (function code), data_i (8 payload bytes), sum_o (8-bit sum).
module package_checksum
  import package_defs::*;
(
  input  logic [7:0]  func_i,
  input  logic [63:0] data_i,
  output logic [7:0]  sum_o
);

  always_comb begin
    sum_o = PACKAGE_START_BYTE + func_i;
    for (int k = 0; k < PAYLOAD_BYTES; k++) begin
      sum_o = sum_o + data_i[8*k +: 8];
    end
  end

endmodule

// File: rtl/package_framer_tx.sv
// Transmit framer: turns one request (func + 8 bytes) into an 11-byte package
// pushed byte by byte into the BlueTooth request FIFO.
// Ports: clk, rst_n, pkg_func_i/pkg_data_i/pkg_vld_i/pkg_rdy_o (request side),
//        fifo_data_o/fifo_data_o_vld/fifo_data_i_rdy (FIFO side), busy_o, pkg_cnt_o.
module package_framer_tx
  import package_defs::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  pkg_func_i,
  input  logic [63:0]                 pkg_data_i,
  input  logic                        pkg_vld_i,
  output logic                        pkg_rdy_o,
  output logic [DATA_WIDTH-1:0]       fifo_data_o,
  output logic                        fifo_data_o_vld,
  input  logic                        fifo_data_i_rdy,
  output logic                        busy_o,
  output logic [PACKAGE_NO_INDEX-1:0] pkg_cnt_o
);

  tx_state_e                   state_q, state_d;
  logic [3:0]                  idx_q, idx_d;
  logic [7:0]                  func_q, func_d;
  logic [63:0]                 data_q, data_d;
  logic [7:0]                  sum_q, sum_d;
  logic [7:0]                  out_q, out_d;
  logic                        vld_q, vld_d;
  logic                        rdy_q, rdy_d;
  logic [PACKAGE_NO_INDEX-1:0] cnt_q, cnt_d;

  logic [7:0] in_sum;
  logic [3:0] nxt_idx;
  logic [2:0] pay_idx;
  logic [7:0] nxt_byte;

  package_checksum u_sum (
    .func_i (pkg_func_i),
    .data_i (pkg_data_i),
    .sum_o  (in_sum)
  );

  // Byte following the one on the bus; index 0 (start byte) is
  // loaded directly at accept time, so only 1..10 appear here.
  assign nxt_idx = idx_q + 4'd1;
  assign pay_idx = nxt_idx[2:0] - 3'd2;

  always_comb begin
    nxt_byte = sum_q;
    if (nxt_idx == 4'd1) begin
      nxt_byte = func_q;
    end else if (nxt_idx < LAST_IDX) begin
      nxt_byte = data_q[{pay_idx, 3'b000} +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    func_d  = func_q;
    data_d  = data_q;
    sum_d   = sum_q;
    out_d   = out_q;
    vld_d   = vld_q;
    rdy_d   = rdy_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        rdy_d = 1'b1;
        if (pkg_vld_i && rdy_q) begin
          func_d  = pkg_func_i;
          data_d  = pkg_data_i;
          sum_d   = in_sum;
          idx_d   = 4'd0;
          out_d   = PACKAGE_START_BYTE;
          vld_d   = 1'b1;
          rdy_d   = 1'b0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (fifo_data_i_rdy) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 4'd0;
            out_d   = '0;
            vld_d   = 1'b0;
            rdy_d   = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = nxt_idx;
            out_d = nxt_byte;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      func_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      func_q  <= func_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pkg_rdy_o       = rdy_q;
  assign fifo_data_o     = out_q;
  assign fifo_data_o_vld = vld_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign pkg_cnt_o       = cnt_q;

endmodule

// File: tb/tb_package_framer_tx.sv
// Bench for package_framer_tx: directed + random requests against a
// byte-stream model; FIFO ready driven always-on, toggling or random.
module tb_package_framer_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pkg_func_i = '0;
  logic [63:0] pkg_data_i = '0;
  logic        pkg_vld_i = 1'b0;
  logic        pkg_rdy_o;
  logic [7:0]  fifo_data_o;
  logic        fifo_data_o_vld;
  logic        fifo_data_i_rdy = 1'b0;
  logic        busy_o;
  logic [5:0]  pkg_cnt_o;

  package_framer_tx dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pkg_func_i      (pkg_func_i),
    .pkg_data_i      (pkg_data_i),
    .pkg_vld_i       (pkg_vld_i),
    .pkg_rdy_o       (pkg_rdy_o),
    .fifo_data_o     (fifo_data_o),
    .fifo_data_o_vld (fifo_data_o_vld),
    .fifo_data_i_rdy (fifo_data_i_rdy),
    .busy_o          (busy_o),
    .pkg_cnt_o       (pkg_cnt_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int viol = 0;
  int rdy_mode = 0;
  int exp_cnt = 0;
  int ptr = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         acc_cyc[$];
  int         req_cyc[$];

  logic       prev_vld = 1'b0;
  logic       prev_rdy = 1'b0;
  logic [7:0] prev_data = '0;

  logic [7:0] lit1[11] = '{8'h55, 8'h51, 8'h01, 8'h02,
                           8'h03, 8'h04, 8'h05, 8'h06,
                           8'h07, 8'h08, 8'hCA};
  logic [7:0] lit3[11] = '{8'h55, 8'h53, 8'hFF, 8'hFF,
                           8'hFF, 8'hFF, 8'hFF, 8'hFF,
                           8'hFF, 8'hFF, 8'hA0};

  // Reference: a package is start, func, payload low byte
  // first, then the mod-256 sum of the ten bytes before it.
  function automatic void model(input logic [7:0] f,
                                input logic [63:0] d);
    logic [7:0] b[11];
    int s;
    b[0] = 8'h55;
    b[1] = f;
    for (int k = 0; k < 8; k++) b[2+k] = d[8*k +: 8];
    s = 0;
    for (int i = 0; i < 10; i++) s = s + int'(b[i]);
    b[10] = 8'(s % 256);
    for (int i = 0; i < 11; i++) exp_q.push_back(b[i]);
  endfunction

  always @(negedge clk) begin
    case (rdy_mode)
      0: fifo_data_i_rdy = 1'b1;
      1: fifo_data_i_rdy = ~fifo_data_i_rdy;
      default: fifo_data_i_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: collects accepted bytes/requests, checks stall stability,
  // and drops the unsent tail of a package abandoned by reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
      prev_vld <= 1'b0;
    end else begin
      if ((prev_vld && !prev_rdy &&
           (!fifo_data_o_vld || fifo_data_o !== prev_data)) ||
          (busy_o !== fifo_data_o_vld))
        viol <= viol + 1;
      if (fifo_data_o_vld && fifo_data_i_rdy) begin
        got_q.push_back(fifo_data_o);
        acc_cyc.push_back(cyc);
      end
      if (pkg_vld_i && pkg_rdy_o) begin
        model(pkg_func_i, pkg_data_i);
        req_cyc.push_back(cyc);
      end
      prev_vld  <= fifo_data_o_vld;
      prev_rdy  <= fifo_data_i_rdy;
      prev_data <= fifo_data_o;
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  task automatic send(input logic [7:0] f,
                      input logic [63:0] d);
    int n;
    @(negedge clk);
    pkg_func_i = f;
    pkg_data_i = d;
    pkg_vld_i  = 1'b1;
    n = 0;
    while (!pkg_rdy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("req_timeout", 1, 0);
      pkg_vld_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    pkg_vld_i  = 1'b0;
    pkg_func_i = 8'($urandom);
    pkg_data_i = {$urandom, $urandom};
  endtask

  task automatic wait_bytes(input int target, input string tag);
    int n;
    n = 0;
    while (got_q.size() < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(got_q.size() >= target), 1);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = ptr; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_byte"}, got_q[i], exp_q[i]);
    ptr = got_q.size();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_vld", fifo_data_o_vld, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cnt", pkg_cnt_o, 0);
    check("rst_rdy", pkg_rdy_o, 0);
    check("rst_data", fifo_data_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    check("rst_rdy_up", pkg_rdy_o, 1);
  endtask

  initial begin
    int b;
    int r;
    int n;
    int bad;

    // reset
    rdy_mode = 0;
    do_reset();

    // 1: fixed vector, ready always high, latency
    b = got_q.size();
    send(8'h51, 64'h0807060504030201);
    wait_bytes(b + 11, "t1_wait");
    for (int k = 0; k < 11; k++) check("t1_lit", got_q[b+k], lit1[k]);
    check_stream("t1");
    r = req_cyc.size() - 1;
    check("t1_lat_first", acc_cyc[b] - req_cyc[r], 1);
    check("t1_lat_last", acc_cyc[b+10] - req_cyc[r], 11);
    exp_cnt++;
    check("t1_cnt", pkg_cnt_o, 6'(exp_cnt));
    check("t1_rdy", pkg_rdy_o, 1);
    check("t1_busy", busy_o, 0);

    // 2: same request, ready toggling
    rdy_mode = 1;
    b = got_q.size();
    send(8'h51, 64'h0807060504030201);
    wait_bytes(b + 11, "t2_wait");
    for (int k = 0; k < 11; k++) check("t2_lit", got_q[b+k], lit1[k]);
    check_stream("t2");
    exp_cnt++;
    @(negedge clk);
    check("t2_cnt", pkg_cnt_o, 6'(exp_cnt));

    // 3: all-FF payload, checksum wrap, random ready
    rdy_mode = 2;
    b = got_q.size();
    send(8'h53, '1);
    wait_bytes(b + 11, "t3_wait");
    for (int k = 0; k < 11; k++) check("t3_lit", got_q[b+k], lit3[k]);
    check_stream("t3");
    exp_cnt++;
    @(negedge clk);
    check("t3_cnt", pkg_cnt_o, 6'(exp_cnt));

    // 4: second request held valid while busy
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    b = got_q.size();
    r = req_cyc.size();
    pkg_func_i = 8'h52;
    pkg_data_i = {$urandom, $urandom};
    pkg_vld_i  = 1'b1;
    n = 0;
    while (req_cyc.size() <= r && n < 100) begin
      @(negedge clk);
      n++;
    end
    pkg_func_i = 8'h53;
    pkg_data_i = {$urandom, $urandom};
    n = 0;
    while (req_cyc.size() <= r + 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    pkg_vld_i = 1'b0;
    check("t4_two_accepts", 64'(req_cyc.size()), 64'(r + 2));
    wait_bytes(b + 22, "t4_wait");
    check("t4_gap", req_cyc[r+1] - acc_cyc[b+10], 1);
    check("t4_first_b", acc_cyc[b+11] - req_cyc[r+1], 1);
    check_stream("t4");
    exp_cnt += 2;
    check("t4_cnt", pkg_cnt_o, 6'(exp_cnt));

    // 5: reset after 5 bytes, then a fresh package
    b = got_q.size();
    send(8'($urandom), {$urandom, $urandom});
    wait_bytes(b + 5, "t5_wait5");
    check("t5_five", got_q.size(), b + 5);
    do_reset();
    check_stream("t5_abort");
    b = got_q.size();
    send(8'($urandom), {$urandom, $urandom});
    wait_bytes(b + 11, "t5_wait");
    check("t5_start", got_q[b], 8'h55);
    check_stream("t5");
    exp_cnt++;
    check("t5_cnt", pkg_cnt_o, 6'(exp_cnt));

    // 6: 64 back-to-back packages, counter wrap, throughput
    do_reset();
    b = got_q.size();
    r = req_cyc.size();
    pkg_func_i = 8'($urandom);
    pkg_data_i = {$urandom, $urandom};
    pkg_vld_i  = 1'b1;
    for (int p = 0; p < 64; p++) begin
      n = 0;
      while (req_cyc.size() <= r + p && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        check("t6_timeout", 1, 0);
        break;
      end
      if (p == 63) begin
        check("t6_cnt63", pkg_cnt_o, 63);
        pkg_vld_i = 1'b0;
      end
      pkg_func_i = 8'($urandom);
      pkg_data_i = {$urandom, $urandom};
    end
    pkg_vld_i = 1'b0;
    wait_bytes(b + 64 * 11, "t6_wait");
    bad = 0;
    for (int p = 1; p < 64; p++)
      if (req_cyc[r+p] - req_cyc[r+p-1] != 12) bad++;
    check("t6_tput", bad, 0);
    check_stream("t6");
    check("t6_cnt_wrap", pkg_cnt_o, 0);

    check("stall_stability", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
